seg7_scan_drv: RTL and testbench

Multiplexed 4-digit seven-segment display driver: the consuming end of the watch core's digit outputs. It takes four 7-bit digit values (hours tens/units, minutes tens/units) with a load strobe and double-buffers them so a frame never tears. It time-multiplexes the anodes, decodes each digit to active-low segments and blinks the colon decimal point. It sits between the watch core and the board's display pins.

---
 rtl/watch_disp_pkg.sv | 26 ++
 rtl/seg7_decode.sv | 16 +
 rtl/seg7_scan_drv.sv | 137 +++++++++++++
 tb/tb_seg7_scan_drv.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/watch_disp_pkg.sv
// Shared types and segment constants for the watch display path.
// Segment encodings are active-low {g,f,e,d,c,b,a}.
package watch_disp_pkg;

   typedef logic [6:0] digit_t;
   typedef logic [6:0] seg_t;

   localparam int NUM_DIGITS = 4;

   localparam seg_t SEG_BLANK = 7'h7F;
   localparam seg_t SEG_DASH  = 7'h3F;

   localparam seg_t SEG_GLYPH [10] = '{
      7'h40,   // 0
      7'h79,   // 1
      7'h24,   // 2
      7'h30,   // 3
      7'h19,   // 4
      7'h12,   // 5
      7'h02,   // 6
      7'h78,   // 7
      7'h00,   // 8
      7'h10    // 9
   };

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-to-segment decoder; anything above 9 renders as a dash.
module seg7_decode
   import watch_disp_pkg::*;
(
   input  logic [6:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      if (digit < 7'd10) begin
         seg = SEG_GLYPH[digit[3:0]];
      end
   end

endmodule

// File: rtl/seg7_scan_drv.sv
// Multiplexed 4-digit seven-segment scanner with double-buffered digits and colon blink.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks slot 0 when the leftmost digit is 0.
module seg7_scan_drv
   import watch_disp_pkg::*;
#(
   parameter int CLK_DIV   = 50000,
   parameter int GUARD     = 1,
   parameter int BLINK_DIV = 125
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] dig0,
   input  logic [6:0] dig1,
   input  logic [6:0] dig2,
   input  logic [6:0] dig3,
   input  logic       load,
   input  logic       colon_en,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an,
   output logic       frame_done
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [1:0]       slot_q, slot_d;
   logic [BLK_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             colon_ph_q, colon_ph_d;

   seg_t             seg_q, seg_d;
   logic             dp_q, dp_d;
   logic [3:0]       an_q, an_d;
   logic             frame_done_q, frame_done_d;

   logic             div_last;
   logic             frame_end;
   logic             guard_on;

   digit_t [NUM_DIGITS-1:0] dig_in;
   digit_t [NUM_DIGITS-1:0] active_vec;
   seg_t   [NUM_DIGITS-1:0] glyph_vec;

   assign dig_in = {dig3, dig2, dig1, dig0};

   // The frame boundary is the terminal count of slot 3; active regs swap exactly there.
   assign div_last  = (div_cnt_q == DIV_LAST);
   assign frame_end = div_last && (slot_q == 2'd3);
   assign guard_on  = (int'(div_cnt_q) < GUARD);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         digit_t shadow_q, shadow_d;
         digit_t active_q, active_d;

         // A load landing on the boundary flows through shadow_d straight into active.
         always_comb begin
            shadow_d = load ? dig_in[gi] : shadow_q;
            active_d = frame_end ? shadow_d : active_q;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               shadow_q <= '0;
               active_q <= '0;
            end else begin
               shadow_q <= shadow_d;
               active_q <= active_d;
            end
         end

         assign active_vec[gi] = active_q;

         seg7_decode u_decode (
            .digit (active_q),
            .seg   (glyph_vec[gi])
         );
      end
   endgenerate

   always_comb begin
      div_cnt_d    = div_last ? '0 : div_cnt_q + 1'b1;
      slot_d       = div_last ? slot_q + 2'd1 : slot_q;
      frame_cnt_d  = frame_cnt_q;
      colon_ph_d   = colon_ph_q;
      if (frame_end) begin
         if (frame_cnt_q == BLK_LAST) begin
            frame_cnt_d = '0;
            colon_ph_d  = ~colon_ph_q;
         end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end

      seg_d = glyph_vec[slot_q];
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if ((slot_q == 2'd0) && (active_vec[0] == 7'd0)) begin
         seg_d = SEG_BLANK;
      end
`endif
      an_d         = guard_on ? 4'hF : ~(4'b0001 << slot_q);
      dp_d         = ~((slot_q == 2'd1) && colon_en && colon_ph_q && !guard_on);
      frame_done_d = frame_end;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q    <= '0;
         slot_q       <= '0;
         frame_cnt_q  <= '0;
         colon_ph_q   <= 1'b0;
         seg_q        <= SEG_BLANK;
         dp_q         <= 1'b1;
         an_q         <= 4'hF;
         frame_done_q <= 1'b0;
      end else begin
         div_cnt_q    <= div_cnt_d;
         slot_q       <= slot_d;
         frame_cnt_q  <= frame_cnt_d;
         colon_ph_q   <= colon_ph_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Directed bench for seg7_scan_drv with CLK_DIV=4, GUARD=1, BLINK_DIV=2.
module tb_seg7_scan_drv;

   localparam int CLK_DIV   = 4;
   localparam int GUARD     = 1;
   localparam int BLINK_DIV = 2;
   localparam int FRAME     = 4 * CLK_DIV;

`ifdef SEG_LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LZ = 7'h7F;
`else
   localparam logic [6:0] LZ = 7'h40;
`endif

   typedef struct packed {
      logic [3:0][6:0] d;
      logic            col;
      logic [3:0][6:0] e;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] dig0, dig1, dig2, dig3;
   logic       load, colon_en;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;
   logic       frame_done;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;
   vec_t vecs [4];

   seg7_scan_drv #(
      .CLK_DIV   (CLK_DIV),
      .GUARD     (GUARD),
      .BLINK_DIV (BLINK_DIV)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .dig0       (dig0),
      .dig1       (dig1),
      .dig2       (dig2),
      .dig3       (dig3),
      .load       (load),
      .colon_en   (colon_en),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Posedges since reset release: after edge k the outputs show state index k-1.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   function automatic vec_t mk(input logic [6:0] d0, input logic [6:0] d1,
                               input logic [6:0] d2, input logic [6:0] d3,
                               input logic col,
                               input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3);
      vec_t r;
      r.d   = {d3, d2, d1, d0};
      r.col = col;
      r.e   = {e3, e2, e1, e0};
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic wait_fd(output int waited);
      waited = 0;
      while (frame_done !== 1'b1 && waited < FRAME + 8) begin
         @(negedge clk);
         waited++;
      end
      chk("frame_done_seen", {31'd0, frame_done}, 32'd1);
   endtask

   // Checks the 16 cycles following a frame_done sample against the timing model.
   task automatic check_frame(input logic [3:0][6:0] e);
      int s, slot, dv, ph;
      logic [3:0] exp_an;
      logic       exp_dp;
      for (int j = 1; j <= FRAME; j++) begin
         @(negedge clk);
         s      = cyc - 1;
         slot   = (s / CLK_DIV) % 4;
         dv     = s % CLK_DIV;
         ph     = (s / (FRAME * BLINK_DIV)) % 2;
         exp_an = (dv < GUARD) ? 4'hF : ~(4'b0001 << slot);
         exp_dp = !((slot == 1) && colon_en && (ph == 1) && (dv >= GUARD));
         chk("an", {28'd0, an}, {28'd0, exp_an});
         if (exp_an != 4'hF) chk("seg", {25'd0, seg}, {25'd0, e[slot]});
         chk("dp", {31'd0, dp}, {31'd0, exp_dp});
         chk("frame_done", {31'd0, frame_done}, {31'd0, (j == FRAME)});
      end
   endtask

   task automatic set_digs(input logic [3:0][6:0] d);
      dig0 = d[0];
      dig1 = d[1];
      dig2 = d[2];
      dig3 = d[3];
   endtask

   initial begin
      int w;
      vecs[0] = mk(7'd1,   7'd2, 7'd3,  7'd4,  1'b0, 7'h79, 7'h24, 7'h30, 7'h19);
      vecs[1] = mk(7'd0,   7'd9, 7'd12, 7'd8,  1'b1, LZ,    7'h10, 7'h3F, 7'h00);
      vecs[2] = mk(7'd127, 7'd6, 7'd7,  7'd10, 1'b1, 7'h3F, 7'h02, 7'h78, 7'h3F);
      vecs[3] = mk(7'd5,   7'd6, 7'd7,  7'd8,  1'b1, 7'h12, 7'h02, 7'h78, 7'h00);

      rst_n = 1'b0; load = 1'b0; colon_en = 1'b0;
      dig0 = '0; dig1 = '0; dig2 = '0; dig3 = '0;
      repeat (3) @(negedge clk);
      chk("rst_seg", {25'd0, seg}, 32'h7F);
      chk("rst_an", {28'd0, an}, 32'hF);
      chk("rst_dp", {31'd0, dp}, 32'd1);
      chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
      $display("reset held: seg=%h an=%h dp=%b", seg, an, dp);

      rst_n = 1'b1;
      @(negedge clk);
      chk("release_guard_an", {28'd0, an}, 32'hF);
      @(negedge clk);
      chk("release_first_an", {28'd0, an}, 32'hE);
      chk("release_first_seg", {25'd0, seg}, {25'd0, LZ});
      $display("reset released: first anode an=%h seg=%h", an, seg);

      for (int i = 0; i < 3; i++) begin
         set_digs(vecs[i].d);
         colon_en = vecs[i].col;
         load = 1'b1;
         @(negedge clk);
         load = 1'b0;
         wait_fd(w);
         check_frame(vecs[i].e);
         $display("vector %0d: digits %0d %0d %0d %0d colon_en=%b checked, checks=%0d",
                  i, vecs[i].d[0], vecs[i].d[1], vecs[i].d[2], vecs[i].d[3], vecs[i].col, n_checks);
      end

      // Back-to-back loads within one frame: the second one must be displayed.
      set_digs({7'd9, 7'd9, 7'd9, 7'd9});
      load = 1'b1;
      @(negedge clk);
      set_digs({7'd1, 7'd4, 7'd1, 7'd3});
      @(negedge clk);
      load = 1'b0;
      wait_fd(w);
      check_frame({7'h79, 7'h19, 7'h79, 7'h30});
      $display("back-to-back load: 9999 then 3141 checked, checks=%0d", n_checks);

      // Load landing exactly on the slot-3 terminal cycle.
      repeat (FRAME - 1) @(negedge clk);
      set_digs(vecs[3].d);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_fd(w);
      chk("collision_boundary_now", w, 0);
      check_frame(vecs[3].e);
      $display("collision load 5678 at frame boundary checked, checks=%0d", n_checks);

      // Asynchronous reset in the middle of slot 2.
      repeat (2 * CLK_DIV + 2) @(negedge clk);
      chk("pre_reset_an", {28'd0, an}, 32'hB);
      chk("pre_reset_seg", {25'd0, seg}, 32'h78);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_seg", {25'd0, seg}, 32'h7F);
      chk("midrst_an", {28'd0, an}, 32'hF);
      chk("midrst_dp", {31'd0, dp}, 32'd1);
      chk("midrst_frame_done", {31'd0, frame_done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check_frame({7'h40, 7'h40, 7'h40, LZ});
      $display("mid-slot reset: restart frame shows 0000, checks=%0d", n_checks);

      // colon_en=0 keeps dp high even in a colon_ph=1 frame, then re-enable.
      colon_en = 1'b0;
      check_frame({7'h40, 7'h40, 7'h40, LZ});
      check_frame({7'h40, 7'h40, 7'h40, LZ});
      colon_en = 1'b1;
      check_frame({7'h40, 7'h40, 7'h40, LZ});
      $display("colon disable/enable frames checked, checks=%0d", n_checks);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout at cycle %0d: got running, expected finished", cyc);
      $fatal(1, "timeout");
   end

endmodule
